// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types and helpers for the memory-access stage.
//   msize_t      : access size encoding (B/H/W/D = 1/2/4/8 bytes)
//   mem_state_t  : memory-stage FSM states
//   size_mask()  : byte-strobe pattern for a size, before lane shifting
//   is_misaligned(): true when a lane offset is not a multiple of the size
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_t;

    localparam int LANE_OFF_W = 3;

    function automatic logic [7:0] size_mask(input msize_t sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input msize_t sz, input logic [LANE_OFF_W-1:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_extend.sv
// -----------------------------------------------------------------------------
// mem_extend
// Combinational load-data alignment: shifts the addressed byte lane down to
// bit 0, truncates to the access size and sign- or zero-extends to DATA_W.
// Ports:
//   raw_data  in  DATA_W  raw bus read data
//   lane_off  in  3       byte offset of the access within the bus word
//   size      in  msize_t access size
//   sign_ext  in  1       1 = sign-extend, 0 = zero-extend
//   ext_data  out DATA_W  aligned, extended result
// -----------------------------------------------------------------------------
module mem_extend
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]     raw_data,
    input  logic [LANE_OFF_W-1:0] lane_off,
    input  msize_t                size,
    input  logic                  sign_ext,
    output logic [DATA_W-1:0]     ext_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted  = raw_data >> {lane_off, 3'b000};
        ext_data = shifted;
        case (size)
            SZ_B:    ext_data = {{(DATA_W-8){sign_ext & shifted[7]}},   shifted[7:0]};
            SZ_H:    ext_data = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_W:    ext_data = {{(DATA_W-32){sign_ext & shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory stage: turns the Ex/Mem load/store payload into a single data-bus
// request, stalls the pipeline while it is outstanding, and presents the
// aligned/extended load result (0 for stores) toward Mem/WB.
//
// Build option: MEM_MISALIGN_CHECK_EN
//   defined   : size-misaligned ops skip the bus, go straight to DONE with
//               res_data=0 and the extra output 'misalign' asserted.
//   undefined : no check; misaligned ops issue normally, strobe bits that
//               shift past lane 7 are dropped.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   op_*         Ex/Mem payload (valid, load, store, addr, wdata, size, signed)
//   flush        kill current instruction
//   wb_stall     Mem/WB not accepting
//   dreq_*       bus request (valid, addr, size, strobe, wdata); zero when idle
//   dresp_ok/dresp_data  bus response pulse and raw read data
//   mem_stall    hold request to hazard unit
//   res_valid/res_data   result toward Mem/WB
//   misalign     (MEM_MISALIGN_CHECK_EN only) misaligned op flagged in DONE
//
// State    | meaning
// ---------+-----------------------------------------------------
// IDLE     | no transaction
// WAIT     | request outstanding, pipeline stalled
// DONE     | result held for handoff to Mem/WB
// DRAIN    | request outstanding for a flushed instruction
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic                op_load,
    input  logic                op_store,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic [1:0]          op_size,
    input  logic                op_signed,
    input  logic                flush,
    input  logic                wb_stall,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [1:0]          dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_wdata,
    input  logic                dresp_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic                mem_stall,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                misalign,
`endif
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data
);

    localparam int STRB_W = DATA_W / 8;

    mem_state_t        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    msize_t            size_q,   size_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              signed_q, signed_d;
    logic              load_q,   load_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
`endif

    logic              is_mem_op;
    logic [DATA_W-1:0] ext_data;

    // Extension works off the latched request, so the Ex/Mem payload is free
    // to change while the response is pending.
    mem_extend #(
        .DATA_W (DATA_W)
    ) u_extend (
        .raw_data (dresp_data),
        .lane_off (addr_q[LANE_OFF_W-1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= SZ_B;
            wdata_q  <= '0;
            signed_q <= 1'b0;
            load_q   <= 1'b0;
            rdata_q  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            signed_q <= signed_d;
            load_q   <= load_d;
            rdata_q  <= rdata_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        signed_d = signed_q;
        load_d   = load_q;
        rdata_d  = rdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
        misalign   = 1'b0;
`endif
        is_mem_op   = op_load | op_store;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = 2'd0;
        dreq_strobe = '0;
        dreq_wdata  = '0;
        mem_stall   = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && is_mem_op && !flush) begin
                    addr_d    = op_addr;
                    size_d    = msize_t'(op_size);
                    wdata_d   = op_wdata;
                    signed_d  = op_signed;
                    load_d    = op_load;
                    mem_stall = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (is_misaligned(msize_t'(op_size), op_addr[LANE_OFF_W-1:0])) begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                        state_d    = ST_DONE;
                    end else begin
                        misalign_d = 1'b0;
                        state_d    = ST_WAIT;
                    end
`else
                    state_d   = ST_WAIT;
`endif
                end else if (op_valid && !is_mem_op && !flush) begin
                    // Non-memory instruction passes straight through.
                    res_valid = 1'b1;
                end
            end

            ST_WAIT, ST_DRAIN: begin
                // The bus forbids withdrawing a request, so it stays up in DRAIN.
                dreq_valid = 1'b1;
                dreq_addr  = addr_q;
                dreq_size  = size_q;
                dreq_wdata = wdata_q << {addr_q[LANE_OFF_W-1:0], 3'b000};
                if (!load_q) begin
                    dreq_strobe = STRB_W'(size_mask(size_q)) << addr_q[LANE_OFF_W-1:0];
                end
                if (state_q == ST_WAIT) begin
                    mem_stall = 1'b1;
                    if (dresp_ok) begin
                        rdata_d = load_q ? ext_data : '0;
                        state_d = flush ? ST_IDLE : ST_DONE;
                    end else if (flush) begin
                        state_d = ST_DRAIN;
                    end
                end else if (dresp_ok) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    res_valid = 1'b1;
                    res_data  = rdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign  = misalign_q;
`endif
                    if (!wb_stall) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
